// File: rtl/seg_scroll_ctrl.sv
// Scrolling window over a 16-entry 4-bit message, feeding char3..char0 to the digit mux.
// Optional reverse scrolling (dir input) is compiled in with `define SEG_SCROLL_REVERSE_EN.
module seg_scroll_ctrl #(
  parameter int SCROLL_DIV = 25000000,
  parameter int PRE_W      = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
`ifdef SEG_SCROLL_REVERSE_EN
  input  logic       dir,
`endif
  input  logic [3:0] msg_len,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [3:0] wr_data,
  output logic [3:0] char3,
  output logic [3:0] char2,
  output logic [3:0] char1,
  output logic [3:0] char0,
  output logic       busy,
  output logic       wrap,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCROLL_DIV - 1);

  state_t           state;
  logic [PRE_W-1:0] pre;
  logic [3:0]       ptr;
  logic [3:0]       mem [16];

  logic       tick;
  logic [4:0] len;
  logic [3:0] ptr_step;
  logic       step_wraps;

  assign dbg_state = state;
  assign len       = {1'b0, msg_len} + 5'd1;
  // A tick only happens on a clock where the FSM stays in RUN.
  assign tick      = (state == S_RUN) && !stop && !pause && (pre == PRE_LAST);

  always_comb begin
    ptr_step   = (ptr == msg_len) ? 4'd0 : ptr + 4'd1;
    step_wraps = (ptr == msg_len);
`ifdef SEG_SCROLL_REVERSE_EN
    if (dir) begin
      ptr_step   = (ptr == 4'd0) ? msg_len : ptr - 4'd1;
      step_wraps = (ptr == 4'd0);
    end
`endif
  end

  // Full modulo: ptr may briefly exceed the length right after msg_len shrinks.
  function automatic logic [3:0] win_idx(input logic [3:0] p, input logic [1:0] off,
                                         input logic [4:0] l);
    logic [4:0] s;
    s = {1'b0, p} + {3'b000, off};
    return 4'(s % l);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      pre   <= '0;
      ptr   <= '0;
      busy  <= 1'b0;
      wrap  <= 1'b0;
      char3 <= '0;
      char2 <= '0;
      char1 <= '0;
      char0 <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else begin
      wrap <= 1'b0;

      if (stop) begin
        state <= S_IDLE;
        busy  <= 1'b0;
        pre   <= '0;
      end else if (pause) begin
        if (state == S_RUN) state <= S_PAUSE;
      end else if (start && state != S_RUN) begin
        state <= S_RUN;
        busy  <= 1'b1;
      end else if (state == S_RUN) begin
        pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
      end

      if (ptr > msg_len || stop) begin
        ptr <= '0;
      end else if (tick) begin
        ptr  <= ptr_step;
        wrap <= step_wraps;
      end

      if (wr_en) mem[wr_addr] <= wr_data;

      char3 <= mem[win_idx(ptr, 2'd0, len)];
      char2 <= mem[win_idx(ptr, 2'd1, len)];
      char1 <= mem[win_idx(ptr, 2'd2, len)];
      char0 <= mem[win_idx(ptr, 2'd3, len)];
    end
  end

endmodule

// File: tb/tb_seg_scroll_ctrl.sv
// Bench for seg_scroll_ctrl: directed scenarios then random commands/writes,
// every cycle compared against a message-level reference model.
module tb_seg_scroll_ctrl;
  localparam int DIV = 4;
  localparam int PW  = 3;
  localparam int W   = 18;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic       clk = 1'b0;
  logic       reset, start, pause, stop, wr_en;
  logic [3:0] msg_len, wr_addr, wr_data;
  logic [3:0] char3, char2, char1, char0;
  logic       busy, wrap;
  logic [1:0] dbg_state;
`ifdef SEG_SCROLL_REVERSE_EN
  logic       dir = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;
  int wrap_seen = 0;
  logic [W-1:0] exp_q[$];

  // reference model: message contents, position, run-cycle phase, mode
  int m_mem [16];
  int m_ptr   = 0;
  int m_cnt   = 0;
  int m_state = M_IDLE;

  seg_scroll_ctrl #(.SCROLL_DIV(DIV), .PRE_W(PW)) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .stop(stop),
`ifdef SEG_SCROLL_REVERSE_EN
    .dir(dir),
`endif
    .msg_len(msg_len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .char3(char3), .char2(char2), .char1(char1), .char0(char0),
    .busy(busy), .wrap(wrap), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    int len, nptr;
    logic [15:0] win;
    logic tick, wr;
    len = int'(msg_len) + 1;
    win = '0;
    for (int i = 0; i < 4; i++) win[(3-i)*4 +: 4] = 4'(m_mem[(m_ptr + i) % len]);
    if (reset) begin
      for (int i = 0; i < 16; i++) m_mem[i] = 0;
      m_ptr = 0; m_cnt = 0; m_state = M_IDLE;
      exp_q.push_back({1'b0, 1'b0, 16'h0000});
      return;
    end
    tick = 1'b0;
    wr   = 1'b0;
    if (stop) begin
      m_state = M_IDLE; m_cnt = 0;
    end else if (pause) begin
      if (m_state == M_RUN) m_state = M_PAUSE;
    end else if (start && m_state != M_RUN) begin
      m_state = M_RUN;
    end else if (m_state == M_RUN) begin
      m_cnt++;
      if (m_cnt == DIV) begin m_cnt = 0; tick = 1'b1; end
    end
    if (m_ptr > int'(msg_len) || stop) begin
      m_ptr = 0;
    end else if (tick) begin
      nptr  = (m_ptr + 1) % len;
      wr    = (nptr == 0);
      m_ptr = nptr;
    end
    if (wr_en) m_mem[wr_addr] = int'(wr_data);
    exp_q.push_back({wr, (m_state != M_IDLE), win});
  endtask

  task automatic step();
    logic [W-1:0] e;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    e = exp_q.pop_front();
    check("window", {16'h0, char3, char2, char1, char0}, {16'h0, e[15:0]});
    check("busy", {31'h0, busy}, {31'h0, e[16]});
    check("wrap", {31'h0, wrap}, {31'h0, e[17]});
    if (wrap === 1'b1) wrap_seen++;
  endtask

  task automatic write_mem(input int a, input int d);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = 4'(d);
    step();
    wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; msg_len = '0;
    step();
    check("reset_window", {16'h0, char3, char2, char1, char0}, 32'h0);
    step();
    reset = 1'b0;
    step();

    // six-character message, forward scrolling
    for (int i = 0; i < 6; i++) write_mem(i, i + 1);
    msg_len = 4'd5;
    step(); step();
    start = 1'b1;
    step();
    check("first_window", {16'h0, char3, char2, char1, char0}, 32'h1234);
    wrap_seen = 0;
    repeat (27) step();
    check("one_wrap", wrap_seen, 1);

    // pause with start still held, then resume
    repeat (5) step();
    pause = 1'b1;
    repeat (10) step();
    check("pause_busy", {31'h0, busy}, 32'h1);
    pause = 1'b0;
    repeat (12) step();

    // stop, then stop together with start
    start = 1'b0; stop = 1'b1;
    step();
    check("stop_busy", {31'h0, busy}, 32'h0);
    start = 1'b1;
    step();
    check("stop_start_busy", {31'h0, busy}, 32'h0);
    stop = 1'b0; start = 1'b0;
    step(); step();

    // length one: every digit shows mem[0]
    msg_len = 4'd0;
    write_mem(0, 7);
    step();
    check("len1_window", {16'h0, char3, char2, char1, char0}, 32'h7777);
    start = 1'b1;
    repeat (12) step();

    // full 16-entry message mem[i]=i
    start = 1'b0; stop = 1'b1;
    step();
    stop = 1'b0;
    for (int i = 0; i < 16; i++) write_mem(i, i);
    msg_len = 4'd15;
    start = 1'b1;
    wrap_seen = 0;
    repeat (70) step();
    check("len16_wrap", wrap_seen, 1);

    // shrink length while pointer is beyond the new end, then write while running
    stop = 1'b1; step(); stop = 1'b0;
    repeat (22) step();
    msg_len = 4'd2;
    wrap_seen = 0;
    step(); step();
    check("shrink_no_wrap", wrap_seen, 0);
    repeat (6) step();
    write_mem(0, 9);
    repeat (8) step();

    // random phase
    for (int n = 0; n < 2000; n++) begin
      reset = ($urandom_range(0, 249) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      pause = ($urandom_range(0, 11) == 0);
      start = ($urandom_range(0, 3) != 0);
      wr_en = ($urandom_range(0, 5) == 0);
      wr_addr = 4'($urandom_range(0, 15));
      wr_data = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) msg_len = 4'($urandom_range(0, 15));
      step();
    end
    reset = 1'b0; stop = 1'b0; pause = 1'b0; start = 1'b0; wr_en = 1'b0;

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
